pci_axi_wr_frontend: RTL and testbench
======================================

Name: pci_axi_wr_frontend

Overview:
- Upstream feeder for the PCI master write path.
- Accepts AXI4 write bursts (AW/W/B) from the DMA fabric and stores beats in a 1024-word ring buffer.
- Buffer is read asynchronously by the PCI master through wdata_idx/wdata_dout/wdata_strb.
- Issues one wcmd per burst after the burst's last beat is stored; converts wresp into AXI B responses.

Parameters:
- CMD_DEPTH, 4: entries in the pending-command FIFO; power of 2, 2..16.
- BUF_AW, 10: ring buffer address width (1024 words). Must match the wdata_idx width.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- s_axi_awid  in  4  burst ID.
- s_axi_awaddr  in  64  byte address.
- s_axi_awlen  in  8  beats-1.
- s_axi_awvalid  in  1.
- s_axi_awready  out  1.
- s_axi_wdata  in  32.
- s_axi_wstrb  in  4.
- s_axi_wlast  in  1.
- s_axi_wvalid  in  1.
- s_axi_wready  out  1.
- s_axi_bid  out  4.
- s_axi_bresp  out  2.
- s_axi_bvalid  out  1.
- s_axi_bready  in  1.
- wdata_idx  in  10  buffer read index from the PCI master.
- wdata_dout  out  32  combinational read of data[wdata_idx].
- wdata_strb  out  4  combinational read of strb[wdata_idx].
- wcmd_id  out  4.
- wcmd_len  out  8  beats-1.
- wcmd_addr  out  64.
- wcmd_valid  out  1.
- wcmd_ready  in  1.
- wresp_id  in  4.
- wresp_len  in  8.
- wresp_err  in  2.
- wresp_valid  in  1.
- wresp_ready  out  1.
- stat_cmd_cnt  out  16  commands issued (optional feature).
- stat_err_cnt  out  16  non-OK responses (optional feature).

Behaviour:
- Reset values: awready=0, wready=0, bvalid=0, bid=0, bresp=0, wcmd_valid=0, wresp_ready=1, stat counters=0.
- Internal state on reset: wr_ptr=0, free=1024, cmd FIFO empty.
- Buffer RAM contents are not reset.
- Reset mid-burst discards the partial burst. No B response is generated for it.
- Only INCR bursts are supported. FIXED/WRAP bursts are treated as INCR (no awburst port).
- State machine (intake):
  - S_IDLE: awready=1 only when free >= awlen+1 and the cmd FIFO is not full. AW handshake latches id/len/addr and start=wr_ptr, sets free -= awlen+1, goes to S_DATA.
  - S_DATA: wready=1. Each W handshake writes {wdata,wstrb} at wr_ptr, wr_ptr+1 mod 1024, beat_cnt+1.
    - Beat with wlast=1, or with beat_cnt==len: push {id,len,addr} into the cmd FIFO, go to S_IDLE.
    - wlast early (beat_cnt<len): treated as the end of the burst. Remaining reserved words are skipped by setting wr_ptr=start+len+1 so the ring stays aligned. The command still carries the original len.
    - Beats beyond len are impossible by construction: the burst is pushed at beat_cnt==len regardless of wlast.
- Dispatch:
  - The cmd FIFO head drives wcmd_*; wcmd_valid = FIFO not empty.
  - Pop on wcmd_valid && wcmd_ready.
  - wcmd_addr passes through unmodified; the master uses [31:2].
- Ordering invariant: the master consumes the ring strictly in command order starting at index 0 after reset. Commands are issued in AW order, data is contiguous, wrap from 1023 to 0 is seamless.
- Response path:
  - wresp_ready = !bvalid || bready (single-register skid).
  - On wresp handshake: bid=wresp_id, bresp=wresp_err, bvalid=1, free += wresp_len+1. Credit applies regardless of err.
  - If free is reserved by AW and credited by wresp in the same cycle, free = free - (awlen+1) + (wresp_len+1).
- Width rules: free is 11 bits (0..1024). Lengths are extended to 9 bits before +1.
- A burst of 256 beats with free==256 is accepted. free==255 stalls AW until a credit arrives.
- Latency: WLAST handshake at cycle N → wcmd_valid at N+1 if the FIFO was empty. wresp handshake at N → bvalid at N+1.

Optional Feature:
- PCI_WR_STATS_EN defined:
  - stat_cmd_cnt increments on every wcmd handshake.
  - stat_err_cnt increments on every wresp handshake with wresp_err!=0.
  - Both 16-bit wrapping, cleared by rst.
- Undefined: both ports are tied to 0 and no counter registers are built.

Decomposition:
- Shared package pci_pkg holds:
  - RESP_OK=0, RESP_EXOK=1, RESP_SLVERR=2, RESP_DECERR=3.
  - BUF_DEPTH=1024.
  - wr_cmd_t struct {id[3:0], len[7:0], addr[63:0]}.
- One sub-module: pci_cmd_fifo, a synchronous FIFO of wr_cmd_t with depth CMD_DEPTH and full/empty flags. It is reusable for the read path.
- Ring RAM is inferred inline as distributed RAM: synchronous write, asynchronous read.

Test Plan:
- Single beat: AW id=3 len=0 addr=0x1000, W 0xDEADBEEF strb=F → wcmd {3,0,0x1000}. wdata_idx=0 reads 0xDEADBEEF. wresp OK → bid=3 bresp=0.
- 4-beat burst then 2-beat burst → second command's data at idx 4..5. free returns to 1024 after both wresp.
- Fill: 4 bursts of 256 beats with no wresp → fourth accepted (free=0), fifth AW stalls. One wresp with len=255 → fifth accepted next cycle.
- Wrap: after 1020 words consumed, an 8-beat burst occupies idx 1020..1023 and 0..3 with data intact.
- Error: wresp err=3 → bresp=DECERR, free still credited. With PCI_WR_STATS_EN, stat_err_cnt=1.
- B backpressure: bready=0 while two wresp are offered → wresp_ready=0 after the first; second is accepted the cycle bready=1.

Source files
------------

// File: rtl/pci_pkg.sv
// Shared types and constants for the PCI master datapath front-ends.
package pci_pkg;

    localparam logic [1:0] RESP_OK     = 2'd0;
    localparam logic [1:0] RESP_EXOK   = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

    localparam int BUF_DEPTH = 1024;

    typedef struct packed {
        logic [3:0]  id;
        logic [7:0]  len;
        logic [63:0] addr;
    } wr_cmd_t;

endpackage

// File: rtl/pci_cmd_fifo.sv
// Synchronous command FIFO (power-of-2 depth) with full/empty flags; head is
// presented combinationally on dout.
module pci_cmd_fifo
    import pci_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = wr_cmd_t
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     din,
    input  logic pop,
    output T     dout,
    output logic full,
    output logic empty
);
    localparam int AW = $clog2(DEPTH);

    T               mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pci_axi_wr_frontend.sv
// AXI4 write slave feeding the PCI master: bursts land in a ring buffer, one
// wcmd per burst, wresp converted to B. Optional counters: PCI_WR_STATS_EN.
module pci_axi_wr_frontend
    import pci_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int BUF_AW    = $clog2(BUF_DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         s_axi_awid,
    input  logic [63:0]        s_axi_awaddr,
    input  logic [7:0]         s_axi_awlen,
    input  logic               s_axi_awvalid,
    output logic               s_axi_awready,
    input  logic [31:0]        s_axi_wdata,
    input  logic [3:0]         s_axi_wstrb,
    input  logic               s_axi_wlast,
    input  logic               s_axi_wvalid,
    output logic               s_axi_wready,
    output logic [3:0]         s_axi_bid,
    output logic [1:0]         s_axi_bresp,
    output logic               s_axi_bvalid,
    input  logic               s_axi_bready,
    input  logic [BUF_AW-1:0]  wdata_idx,
    output logic [31:0]        wdata_dout,
    output logic [3:0]         wdata_strb,
    output logic [3:0]         wcmd_id,
    output logic [7:0]         wcmd_len,
    output logic [63:0]        wcmd_addr,
    output logic               wcmd_valid,
    input  logic               wcmd_ready,
    input  logic [3:0]         wresp_id,
    input  logic [7:0]         wresp_len,
    input  logic [1:0]         wresp_err,
    input  logic               wresp_valid,
    output logic               wresp_ready,
    output logic [15:0]        stat_cmd_cnt,
    output logic [15:0]        stat_err_cnt
);
    localparam int FREE_W = BUF_AW + 1;

    typedef enum logic {S_IDLE, S_DATA} state_t;

    state_t              state;
    wr_cmd_t             cur_cmd;
    wr_cmd_t             head;
    logic [BUF_AW-1:0]   wr_ptr;
    logic [BUF_AW-1:0]   start_ptr;
    logic [7:0]          beat_cnt;
    logic [FREE_W-1:0]   free;
    logic [8:0]          aw_len9;
    logic [8:0]          resp_len9;
    logic [FREE_W-1:0]   aw_need;
    logic [FREE_W-1:0]   resp_credit;
    logic                fifo_full;
    logic                fifo_empty;
    logic                aw_hs;
    logic                w_hs;
    logic                last_beat;
    logic                wcmd_hs;
    logic                wresp_hs;
    logic [35:0]         ring [1 << BUF_AW];

    // Lengths widen to 9 bits before +1 so awlen=255 reserves 256 words.
    assign aw_len9     = {1'b0, s_axi_awlen} + 9'd1;
    assign resp_len9   = {1'b0, wresp_len} + 9'd1;
    assign aw_need     = FREE_W'(aw_len9);
    assign resp_credit = FREE_W'(resp_len9);

    assign s_axi_awready = (state == S_IDLE) && !rst && !fifo_full && (free >= aw_need);
    assign s_axi_wready  = (state == S_DATA);
    assign aw_hs         = s_axi_awvalid && s_axi_awready;
    assign w_hs          = s_axi_wvalid && s_axi_wready;
    assign last_beat     = w_hs && (s_axi_wlast || (beat_cnt == cur_cmd.len));
    assign wcmd_valid    = !fifo_empty;
    assign wcmd_hs       = wcmd_valid && wcmd_ready;
    assign wresp_ready   = !s_axi_bvalid || s_axi_bready;
    assign wresp_hs      = wresp_valid && wresp_ready;

    assign {wdata_strb, wdata_dout} = ring[wdata_idx];

    always_ff @(posedge clk) begin
        if (w_hs)
            ring[wr_ptr] <= {s_axi_wstrb, s_axi_wdata};
    end

    // Intake FSM. The last beat (wlast or len reached) always re-aligns wr_ptr
    // to the end of the reservation, which also covers an early wlast.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cur_cmd   <= '0;
            wr_ptr    <= '0;
            start_ptr <= '0;
            beat_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (aw_hs) begin
                        cur_cmd   <= '{id: s_axi_awid, len: s_axi_awlen, addr: s_axi_awaddr};
                        start_ptr <= wr_ptr;
                        beat_cnt  <= '0;
                        state     <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_hs) begin
                        beat_cnt <= beat_cnt + 8'd1;
                        if (last_beat) begin
                            wr_ptr <= start_ptr + BUF_AW'(cur_cmd.len) + BUF_AW'(1);
                            state  <= S_IDLE;
                        end else begin
                            wr_ptr <= wr_ptr + BUF_AW'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            free <= FREE_W'(1 << BUF_AW);
        else
            free <= free - (aw_hs ? aw_need : '0) + (wresp_hs ? resp_credit : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_bvalid <= 1'b0;
            s_axi_bid    <= '0;
            s_axi_bresp  <= '0;
        end else if (wresp_hs) begin
            s_axi_bvalid <= 1'b1;
            s_axi_bid    <= wresp_id;
            s_axi_bresp  <= wresp_err;
        end else if (s_axi_bready) begin
            s_axi_bvalid <= 1'b0;
        end
    end

    // The FIFO never overflows: AW is only accepted while it has room and at
    // most one burst is in flight through the intake.
    pci_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .T     (wr_cmd_t)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (last_beat),
        .din   (cur_cmd),
        .pop   (wcmd_hs),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign wcmd_id   = head.id;
    assign wcmd_len  = head.len;
    assign wcmd_addr = head.addr;

`ifdef PCI_WR_STATS_EN
    logic [15:0] cmd_cnt;
    logic [15:0] err_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_cnt <= '0;
            err_cnt <= '0;
        end else begin
            if (wcmd_hs)
                cmd_cnt <= cmd_cnt + 16'd1;
            if (wresp_hs && (wresp_err != RESP_OK))
                err_cnt <= err_cnt + 16'd1;
        end
    end

    assign stat_cmd_cnt = cmd_cnt;
    assign stat_err_cnt = err_cnt;
`else
    assign stat_cmd_cnt = '0;
    assign stat_err_cnt = '0;
`endif

endmodule

// File: tb/tb_pci_axi_wr_frontend.sv
// Directed bench for pci_axi_wr_frontend: intake, ring contents, dispatch,
// credit flow control, wrap and B-channel backpressure.
module tb_pci_axi_wr_frontend;
    import pci_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  s_axi_awid;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [3:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [9:0]  wdata_idx;
    logic [31:0] wdata_dout;
    logic [3:0]  wdata_strb;
    logic [3:0]  wcmd_id;
    logic [7:0]  wcmd_len;
    logic [63:0] wcmd_addr;
    logic        wcmd_valid;
    logic        wcmd_ready;
    logic [3:0]  wresp_id;
    logic [7:0]  wresp_len;
    logic [1:0]  wresp_err;
    logic        wresp_valid;
    logic        wresp_ready;
    logic [15:0] stat_cmd_cnt;
    logic [15:0] stat_err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pci_axi_wr_frontend #(.CMD_DEPTH(4), .BUF_AW(10)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready),
        .wdata_idx(wdata_idx), .wdata_dout(wdata_dout), .wdata_strb(wdata_strb),
        .wcmd_id(wcmd_id), .wcmd_len(wcmd_len), .wcmd_addr(wcmd_addr),
        .wcmd_valid(wcmd_valid), .wcmd_ready(wcmd_ready),
        .wresp_id(wresp_id), .wresp_len(wresp_len), .wresp_err(wresp_err),
        .wresp_valid(wresp_valid), .wresp_ready(wresp_ready),
        .stat_cmd_cnt(stat_cmd_cnt), .stat_err_cnt(stat_err_cnt)
    );

    // Drivers: all enter and leave at posedge+1; ready is sampled at posedge+2.
    task automatic do_reset();
        s_axi_awvalid = 0; s_axi_wvalid = 0; wresp_valid = 0; wcmd_ready = 0;
        s_axi_bready = 1; s_axi_wlast = 0;
        rst = 1;
        @(posedge clk); @(posedge clk); #1;
        rst = 0;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [7:0] len,
                           input logic [63:0] addr, output bit ok);
        bit hs;
        s_axi_awid = id; s_axi_awlen = len; s_axi_awaddr = addr; s_axi_awvalid = 1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            #1; hs = s_axi_awready;
            @(posedge clk); #1;
            if (hs) begin ok = 1; break; end
        end
        s_axi_awvalid = 0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb,
                          input logic last, output bit ok);
        bit hs;
        s_axi_wdata = data; s_axi_wstrb = strb; s_axi_wlast = last; s_axi_wvalid = 1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            #1; hs = s_axi_wready;
            @(posedge clk); #1;
            if (hs) begin ok = 1; break; end
        end
        s_axi_wvalid = 0; s_axi_wlast = 0;
    endtask

    task automatic burst_send(input logic [3:0] id, input logic [7:0] len,
                              input logic [63:0] addr, input logic [31:0] base, output bit ok);
        bit b;
        aw_send(id, len, addr, ok);
        for (int i = 0; i <= int'(len); i++) begin
            w_send(base + 32'(i), 4'hF, (i == int'(len)), b);
            ok = ok & b;
        end
    endtask

    task automatic wresp_send(input logic [3:0] id, input logic [7:0] len,
                              input logic [1:0] err, output bit ok);
        bit hs;
        wresp_id = id; wresp_len = len; wresp_err = err; wresp_valid = 1;
        ok = 0;
        for (int n = 0; n < 100; n++) begin
            #1; hs = wresp_ready;
            @(posedge clk); #1;
            if (hs) begin ok = 1; break; end
        end
        wresp_valid = 0;
    endtask

    task automatic cmd_pop(output wr_cmd_t c, output int waited, output bit ok);
        bit hs;
        ok = 0; waited = -1; c = '0; wcmd_ready = 1;
        for (int n = 0; n < 20; n++) begin
            #1; hs = wcmd_valid;
            if (hs) c = '{id: wcmd_id, len: wcmd_len, addr: wcmd_addr};
            @(posedge clk); #1;
            if (hs) begin ok = 1; waited = n; break; end
        end
        wcmd_ready = 0;
    endtask

    task automatic test_reset();
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, wcmd_valid, wresp_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_ctrl got aw/w/b/wcmd/wresp_rdy=%b exp=00001",
                     {s_axi_awready, s_axi_wready, s_axi_bvalid, wcmd_valid, wresp_ready});
        end
        checks++;
        if ({s_axi_bid, s_axi_bresp, stat_cmd_cnt, stat_err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_vals got bid=%0d bresp=%0d cmd_cnt=%0d err_cnt=%0d exp all 0",
                     s_axi_bid, s_axi_bresp, stat_cmd_cnt, stat_err_cnt);
        end
        rst = 0;
        #1;
        checks++;
        if (s_axi_awready !== 1'b1) begin
            failures++;
            $display("FAIL reset_awready_after got=%b exp=1", s_axi_awready);
        end
    endtask

    task automatic test_single();
        bit ok; wr_cmd_t c; int w;
        burst_send(4'd3, 8'd0, 64'h1000, 32'hDEADBEEF, ok);
        cmd_pop(c, w, ok);
        checks++;
        if (!ok || w != 0 || c !== '{id: 4'd3, len: 8'd0, addr: 64'h1000}) begin
            failures++;
            $display("FAIL single_cmd got ok=%0d wait=%0d id=%0d len=%0d addr=%h exp wait=0 id=3 len=0 addr=1000",
                     ok, w, c.id, c.len, c.addr);
        end
        wdata_idx = 10'd0; #1;
        checks++;
        if (wdata_dout !== 32'hDEADBEEF || wdata_strb !== 4'hF) begin
            failures++;
            $display("FAIL single_data got=%h/%h exp=deadbeef/f", wdata_dout, wdata_strb);
        end
        wresp_send(4'd3, 8'd0, RESP_OK, ok);
        checks++;
        if (!ok || s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'd3 || s_axi_bresp !== 2'd0) begin
            failures++;
            $display("FAIL single_b got ok=%0d bvalid=%b bid=%0d bresp=%0d exp 1/3/0",
                     ok, s_axi_bvalid, s_axi_bid, s_axi_bresp);
        end
    endtask

    task automatic test_two_bursts();
        bit ok1, ok2, ok3, ok4; wr_cmd_t c1, c2; int w;
        do_reset();
        burst_send(4'd1, 8'd3, 64'h2000, 32'h100, ok1);
        burst_send(4'd2, 8'd1, 64'h3000, 32'h200, ok2);
        cmd_pop(c1, w, ok3);
        cmd_pop(c2, w, ok4);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4) || c1 !== '{id: 4'd1, len: 8'd3, addr: 64'h2000}
            || c2 !== '{id: 4'd2, len: 8'd1, addr: 64'h3000}) begin
            failures++;
            $display("FAIL two_cmds got c1=%0d/%0d/%h c2=%0d/%0d/%h exp 1/3/2000 2/1/3000",
                     c1.id, c1.len, c1.addr, c2.id, c2.len, c2.addr);
        end
        wdata_idx = 10'd4; #1;
        checks++;
        if (wdata_dout !== 32'h200) begin
            failures++; $display("FAIL two_idx4 got=%h exp=200", wdata_dout);
        end
        wdata_idx = 10'd5; #1;
        checks++;
        if (wdata_dout !== 32'h201) begin
            failures++; $display("FAIL two_idx5 got=%h exp=201", wdata_dout);
        end
        wdata_idx = 10'd3; #1;
        checks++;
        if (wdata_dout !== 32'h103) begin
            failures++; $display("FAIL two_idx3 got=%h exp=103", wdata_dout);
        end
        wresp_send(4'd1, 8'd3, RESP_OK, ok1);
        wresp_send(4'd2, 8'd1, RESP_OK, ok2);
    endtask

    // Runs without reset after test_two_bursts: the full 1024 must be back.
    task automatic test_fill();
        bit ok, all_ok; bit b;
        all_ok = 1;
        wcmd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            burst_send(4'(k), 8'd255, 64'h10000 + 64'(k) * 64'h400, 32'(k) << 16, ok);
            all_ok = all_ok & ok;
        end
        checks++;
        if (!all_ok) begin
            failures++; $display("FAIL fill_four_accepted got=0 exp=1");
        end
        s_axi_awid = 4'd4; s_axi_awlen = 8'd255; s_axi_awaddr = 64'h20000; s_axi_awvalid = 1;
        repeat (3) @(posedge clk); #2;
        checks++;
        if (s_axi_awready !== 1'b0) begin
            failures++; $display("FAIL fill_fifth_stall got=%b exp=0", s_axi_awready);
        end
        #(-1+1);
        wresp_send(4'd0, 8'd254, RESP_OK, ok);
        #1;
        checks++;
        if (!ok || s_axi_awready !== 1'b0) begin
            failures++; $display("FAIL fill_free255_stall got ok=%0d awready=%b exp 1/0", ok, s_axi_awready);
        end
        wresp_send(4'd1, 8'd0, RESP_OK, ok);
        #1;
        checks++;
        if (!ok || s_axi_awready !== 1'b1) begin
            failures++; $display("FAIL fill_free256_accept got ok=%0d awready=%b exp 1/1", ok, s_axi_awready);
        end
        @(posedge clk); #1;
        s_axi_awvalid = 0;
        for (int i = 0; i < 256; i++) w_send(32'(i), 4'hF, (i == 255), b);
        wcmd_ready = 0;
    endtask

    task automatic test_early_wlast();
        bit ok1, ok2, ok3, ok4, ok5; wr_cmd_t c1, c2; int w;
        do_reset();
        aw_send(4'd5, 8'd3, 64'h4000, ok1);
        w_send(32'hA0, 4'hF, 1'b0, ok2);
        w_send(32'hA1, 4'h3, 1'b1, ok3);
        burst_send(4'd6, 8'd0, 64'h5000, 32'hB0, ok4);
        cmd_pop(c1, w, ok5);
        checks++;
        if (!(ok1 && ok2 && ok3 && ok4 && ok5) || c1 !== '{id: 4'd5, len: 8'd3, addr: 64'h4000}) begin
            failures++;
            $display("FAIL early_cmd got %0d/%0d/%h exp 5/3/4000", c1.id, c1.len, c1.addr);
        end
        cmd_pop(c2, w, ok5);
        checks++;
        if (!ok5 || c2.id !== 4'd6) begin
            failures++; $display("FAIL early_cmd2 got id=%0d exp=6", c2.id);
        end
        wdata_idx = 10'd1; #1;
        checks++;
        if (wdata_dout !== 32'hA1 || wdata_strb !== 4'h3) begin
            failures++; $display("FAIL early_idx1 got=%h/%h exp=a1/3", wdata_dout, wdata_strb);
        end
        wdata_idx = 10'd4; #1;
        checks++;
        if (wdata_dout !== 32'hB0) begin
            failures++; $display("FAIL early_realign_idx4 got=%h exp=b0", wdata_dout);
        end
    endtask

    task automatic test_wrap();
        bit ok, all_ok;
        logic [9:0] idx;
        logic [31:0] exp;
        do_reset();
        all_ok = 1;
        wcmd_ready = 1;
        for (int k = 0; k < 3; k++) begin
            burst_send(4'(k), 8'd255, 64'h0, 32'h0, ok); all_ok = all_ok & ok;
        end
        burst_send(4'd3, 8'd251, 64'h0, 32'h0, ok); all_ok = all_ok & ok;
        wresp_send(4'd0, 8'd255, RESP_OK, ok); all_ok = all_ok & ok;
        burst_send(4'd7, 8'd7, 64'h8000, 32'hC0, ok); all_ok = all_ok & ok;
        wcmd_ready = 0;
        checks++;
        if (!all_ok) begin
            failures++; $display("FAIL wrap_handshakes got=0 exp=1");
        end
        for (int i = 0; i < 8; i++) begin
            idx = 10'(1020 + i);
            exp = 32'hC0 + 32'(i);
            wdata_idx = idx; #1;
            checks++;
            if (wdata_dout !== exp) begin
                failures++; $display("FAIL wrap_idx%0d got=%h exp=%h", idx, wdata_dout, exp);
            end
        end
    endtask

    task automatic test_error();
        bit ok, all_ok;
        do_reset();
        all_ok = 1;
        wcmd_ready = 1;
        for (int k = 0; k < 4; k++) begin
            burst_send(4'(k), 8'd255, 64'h0, 32'h0, ok); all_ok = all_ok & ok;
        end
        repeat (2) @(posedge clk); #1;
        wcmd_ready = 0;
        wresp_send(4'd9, 8'd255, RESP_DECERR, ok); all_ok = all_ok & ok;
        checks++;
        if (!all_ok || s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'd9 || s_axi_bresp !== 2'd3) begin
            failures++;
            $display("FAIL err_b got ok=%0d bvalid=%b bid=%0d bresp=%0d exp 1/1/9/3",
                     all_ok, s_axi_bvalid, s_axi_bid, s_axi_bresp);
        end
        s_axi_awlen = 8'd255; s_axi_awvalid = 1; #1;
        checks++;
        if (s_axi_awready !== 1'b1) begin
            failures++; $display("FAIL err_credit got awready=%b exp=1", s_axi_awready);
        end
        s_axi_awvalid = 0;
`ifdef PCI_WR_STATS_EN
        checks++;
        if (stat_err_cnt !== 16'd1 || stat_cmd_cnt !== 16'd4) begin
            failures++; $display("FAIL err_stats got cmd=%0d err=%0d exp 4/1", stat_cmd_cnt, stat_err_cnt);
        end
`else
        checks++;
        if (stat_err_cnt !== 16'd0 || stat_cmd_cnt !== 16'd0) begin
            failures++; $display("FAIL err_stats_off got cmd=%0d err=%0d exp 0/0", stat_cmd_cnt, stat_err_cnt);
        end
`endif
    endtask

    task automatic test_b_backpressure();
        bit ok1, ok2, ok3;
        do_reset();
        wcmd_ready = 1;
        burst_send(4'd1, 8'd0, 64'h0, 32'h1, ok1);
        burst_send(4'd2, 8'd0, 64'h4, 32'h2, ok2);
        wcmd_ready = 0;
        s_axi_bready = 0;
        wresp_send(4'd1, 8'd0, RESP_OK, ok3);
        checks++;
        if (!(ok1 && ok2 && ok3) || s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'd1) begin
            failures++; $display("FAIL bp_first got bvalid=%b bid=%0d exp 1/1", s_axi_bvalid, s_axi_bid);
        end
        wresp_id = 4'd2; wresp_len = 8'd0; wresp_err = RESP_SLVERR; wresp_valid = 1;
        #1;
        checks++;
        if (wresp_ready !== 1'b0) begin
            failures++; $display("FAIL bp_wresp_ready_low got=%b exp=0", wresp_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (wresp_ready !== 1'b0 || s_axi_bid !== 4'd1 || s_axi_bvalid !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got wresp_ready=%b bid=%0d bvalid=%b exp 0/1/1", wresp_ready, s_axi_bid, s_axi_bvalid);
        end
        s_axi_bready = 1; #1;
        checks++;
        if (wresp_ready !== 1'b1) begin
            failures++; $display("FAIL bp_release_ready got=%b exp=1", wresp_ready);
        end
        @(posedge clk); #1;
        wresp_valid = 0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bid !== 4'd2 || s_axi_bresp !== 2'd2) begin
            failures++;
            $display("FAIL bp_second got bvalid=%b bid=%0d bresp=%0d exp 1/2/2", s_axi_bvalid, s_axi_bid, s_axi_bresp);
        end
        @(posedge clk); #1;
        checks++;
        if (s_axi_bvalid !== 1'b0) begin
            failures++; $display("FAIL bp_drain got bvalid=%b exp=0", s_axi_bvalid);
        end
    endtask

    initial begin
        s_axi_awid = 0; s_axi_awaddr = 0; s_axi_awlen = 0; s_axi_awvalid = 0;
        s_axi_wdata = 0; s_axi_wstrb = 0; s_axi_wlast = 0; s_axi_wvalid = 0;
        s_axi_bready = 1; wdata_idx = 0; wcmd_ready = 0;
        wresp_id = 0; wresp_len = 0; wresp_err = 0; wresp_valid = 0;
        test_reset();
        test_single();
        test_two_bursts();
        test_fill();
        test_early_wlast();
        test_wrap();
        test_error();
        test_b_backpressure();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
